// File: rtl/fmap_serializer_if.sv
// rtl/fmap_serializer_if.sv - valid/ready beat bus carrying feature-map words with their coordinates
interface fmap_serializer_if #(
    parameter int DATA_W = 16
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [2:0]        m_row;
    logic [2:0]        m_col;
    logic              m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_row,
        output m_col,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_row,
        input  m_col,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fmap_serializer.sv
// rtl/fmap_serializer.sv - snapshots a feature map and streams it in raster order; FMAP_SER_CROP_EN streams only the valid conv region
module fmap_serializer #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 6,
    parameter int COLS   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] feature_map_in [0:ROWS*COLS-1],
    output logic              busy,
    output logic              frame_done,
    fmap_serializer_if.master m
);

`ifdef FMAP_SER_CROP_EN
    // Only the unpadded region of the 3x3 convolution output is streamed and stored.
    localparam int S_ROWS = ROWS - 2;
    localparam int S_COLS = COLS - 2;
`else
    localparam int S_ROWS = ROWS;
    localparam int S_COLS = COLS;
`endif
    localparam int S_WORDS = S_ROWS * S_COLS;
    localparam int IDX_W   = $clog2(S_WORDS);
    localparam logic [2:0] LAST_ROW = 3'(S_ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(S_COLS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shadow_q [0:S_WORDS-1];
    logic [DATA_W-1:0] data_q;
    logic [2:0]        row_q;
    logic [2:0]        col_q;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;

    logic [2:0]        row_d;
    logic [2:0]        col_d;
    logic [IDX_W-1:0]  idx_d;
    logic              last_d;

    // Next raster position and its shadow index; only consumed on a non-final handshake.
    always_comb begin
        row_d = row_q;
        col_d = col_q + 3'd1;
        if (col_q == LAST_COL) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
        end
        idx_d  = IDX_W'(row_d) * IDX_W'(S_COLS) + IDX_W'(col_d);
        last_d = (row_d == LAST_ROW) && (col_d == LAST_COL);
    end

    // Shadow bank capture on an accepted start; never cleared so reset costs no extra logic.
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && start) begin
            for (int r = 0; r < S_ROWS; r++) begin
                for (int c = 0; c < S_COLS; c++) begin
                    shadow_q[r*S_COLS + c] <= feature_map_in[r*COLS + c];
                end
            end
        end
    end

    // Control FSM with registered beat outputs; word 0 is taken straight from the input at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= STREAM;
                        data_q  <= feature_map_in[0];
                        row_q   <= '0;
                        col_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= (S_WORDS == 1);
                        busy_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (m.m_ready) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            data_q  <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            data_q <= shadow_q[idx_d];
                            row_q  <= row_d;
                            col_q  <= col_d;
                            last_q <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign m.m_valid  = valid_q;
    assign m.m_data   = data_q;
    assign m.m_row    = row_q;
    assign m.m_col    = col_q;
    assign m.m_last   = last_q;

endmodule

// File: tb/tb_fmap_serializer.sv
// tb/tb_fmap_serializer.sv - scoreboard bench for fmap_serializer (full and FMAP_SER_CROP_EN builds)
module tb_fmap_serializer;

`ifdef FMAP_SER_CROP_EN
    localparam int ER = 4;
    localparam int EC = 4;
`else
    localparam int ER = 6;
    localparam int EC = 6;
`endif
    localparam int NB = ER * EC;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  r;
        logic [2:0]  c;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] fm [0:35];
    logic        busy;
    logic        frame_done;

    fmap_serializer_if #(.DATA_W(16)) m_if ();

    fmap_serializer #(.DATA_W(16), .ROWS(6), .COLS(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .feature_map_in (fm),
        .busy           (busy),
        .frame_done     (frame_done),
        .m              (m_if.master)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    hs_count = 0;
    beat_t exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor: compares every presented beat against the queue head, pops on handshake.
    bit fd_pending = 1'b0;
    bit stall_prev = 1'b0;
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            fd_pending = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("frame_done", frame_done, fd_pending);
            fd_pending = 1'b0;
            if (stall_prev) check("valid_hold", m_if.m_valid, 1);
            if (m_if.m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q[0];
                    check("data", m_if.m_data, b.d);
                    check("row",  m_if.m_row,  b.r);
                    check("col",  m_if.m_col,  b.c);
                    check("last", m_if.m_last, b.l);
                    if (m_if.m_ready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                        if (b.l) fd_pending = 1'b1;
                    end
                end
            end else begin
                check("idle_data", m_if.m_data, 0);
                check("idle_row",  m_if.m_row,  0);
                check("idle_col",  m_if.m_col,  0);
                check("idle_last", m_if.m_last, 0);
            end
            stall_prev = m_if.m_valid && !m_if.m_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        beat_t b;
        for (int r = 0; r < ER; r++) begin
            for (int c = 0; c < EC; c++) begin
                b.d = fm[r*6 + c];
                b.r = 3'(r);
                b.c = 3'(c);
                b.l = (r == ER-1) && (c == EC-1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        push_frame();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check(tag, seen, 1);
    endtask

    task automatic load_ramp(input int base);
        for (int k = 0; k < 36; k++) fm[k] = 16'(k + base);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int    n0;
        int    hs0;
        bit    seen;
        logic [3:0] pat;

        rst = 1'b1;
        start = 1'b0;
        m_if.m_ready = 1'b0;
        load_ramp(0);

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy",  busy, 0);
        check("rst_valid", m_if.m_valid, 0);
        check("rst_data",  m_if.m_data, 0);
        check("rst_row",   m_if.m_row, 0);
        check("rst_col",   m_if.m_col, 0);
        check("rst_last",  m_if.m_last, 0);
        check("rst_done",  frame_done, 0);
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", m_if.m_valid, 0);
        end

        // Full-rate frame
        load_ramp(100);
        hs0 = hs_count;
        pulse_start();
        n0 = cyc;
        check("fr_first_valid", m_if.m_valid, 1);
        check("fr_busy", busy, 1);
        wait_done(NB + 10, "fr_done");
        check("fr_latency", cyc - n0, NB);
        check("fr_handshakes", hs_count - hs0, NB);
        check("fr_valid_drop", m_if.m_valid, 0);
        check("fr_busy_drop", busy, 0);
        tick();

        // Backpressure with snapshot overwrite
        load_ramp(100);
        pat = 4'b1001;
        m_if.m_ready = pat[0];
        hs0 = hs_count;
        pulse_start();
        for (int k = 0; k < 36; k++) fm[k] = 16'hFFFF;
        seen = 1'b0;
        for (int p = 1; p < NB*4 + 20 && !seen; p++) begin
            m_if.m_ready = pat[p % 4];
            tick();
            if (frame_done) seen = 1'b1;
        end
        check("bp_done", seen, 1);
        check("bp_handshakes", hs_count - hs0, NB);
        m_if.m_ready = 1'b1;
        tick();

        // Ignored starts mid-frame and on the final handshake, then back-to-back start
        load_ramp(100);
        hs0 = hs_count;
        pulse_start();
        for (int i = 1; i <= NB; i++) begin
            start = (i == 10) || (i == NB);
            tick();
        end
        start = 1'b0;
        check("ign_done_pulse", frame_done, 1);
        check("ign_valid_low", m_if.m_valid, 0);
        check("ign_handshakes", hs_count - hs0, NB);
        load_ramp(500);
        pulse_start();
        check("b2b_valid", m_if.m_valid, 1);
        check("b2b_busy", busy, 1);
        wait_done(NB + 10, "b2b_done");
        tick();

        // Mid-frame reset
        load_ramp(100);
        hs0 = hs_count;
        pulse_start();
        for (int i = 0; i < 50 && hs_count < hs0 + 11; i++) tick();
        check("mr_reached_beat10", hs_count - hs0, 11);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("mr_valid", m_if.m_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_no_done", frame_done, 0);
        repeat (3) tick();
        for (int k = 0; k < 36; k++) fm[k] = 16'($urandom);
        hs0 = hs_count;
        pulse_start();
        check("mr_restart_row", m_if.m_row, 0);
        check("mr_restart_col", m_if.m_col, 0);
        wait_done(NB + 10, "mr_done");
        check("mr_handshakes", hs_count - hs0, NB);
        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
